// File: rtl/logic_test_pkg.sv
// Shared types, sizes and the golden gate function for the gate-block tester.
package logic_test_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_e;

   localparam int NUM_VEC = 4;
   localparam int VEC_W   = 2;
   localparam int ERR_W   = 3;

   // Golden outputs {x, y, z} of the AND/OR/XOR block for input vector {a, b}.
   function automatic logic [2:0] golden(input logic [1:0] ab);
      return {ab[1] & ab[0], ab[1] | ab[0], ab[1] ^ ab[0]};
   endfunction

endpackage

// File: rtl/logic_test_golden.sv
// Combinational golden-value generator for the two-input gate block.
// Kept as its own module so extra gates can be added in one place.
module logic_test_golden
   import logic_test_pkg::*;
(
   input  logic a_i,
   input  logic b_i,
   output logic exp_x_o,
   output logic exp_y_o,
   output logic exp_z_o
);

   // Expected X/Y/Z for the vector currently applied.
   always_comb begin
      {exp_x_o, exp_y_o, exp_z_o} = golden({a_i, b_i});
   end

endmodule

// File: rtl/logic_test_checker.sv
// Sequential tester for the AND/OR/XOR gate block.
// Applies vectors 00,01,10,11 on a_o/b_o, waits SETTLE_CYC cycles per vector,
// samples x_i/y_i/z_i and records pass, error count and a per-vector fail mask.
// Optional: define LOGIC_TEST_CHECKER_FAIL_LOG_EN to capture the first failing
// vector and which outputs disagreed on first_fail; otherwise first_fail is 0.
//
// Handshake: start is a level sampled only in IDLE; busy is high while a sweep
// runs (SETTLE/CHECK); done pulses for one cycle when results become valid, and
// pass/err_cnt/fail_mask then hold until the next accepted start.
module logic_test_checker
   import logic_test_pkg::*;
#(
   parameter int SETTLE_CYC = 2  // legal range 1..15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             a_o,
   output logic             b_o,
   input  logic             x_i,
   input  logic             y_i,
   input  logic             z_i,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [NUM_VEC-1:0] fail_mask,
   output logic [4:0]       first_fail
);

   // Counter counts down to zero, so SETTLE lasts exactly SETTLE_CYC cycles.
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);
   localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

   state_e               state_q, state_d;
   logic [VEC_W-1:0]     vec_q, vec_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 done_q, done_d;
   logic                 pass_q, pass_d;
   logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;
   logic [NUM_VEC-1:0]   fail_mask_q, fail_mask_d;

   logic exp_x, exp_y, exp_z;
   logic mis_x, mis_yz, mismatch;
   logic start_accept;

   logic_test_golden u_golden (
      .a_i     (vec_q[1]),
      .b_i     (vec_q[0]),
      .exp_x_o (exp_x),
      .exp_y_o (exp_y),
      .exp_z_o (exp_z)
   );

   // Case-inequality so unknown DUT outputs count as failures in simulation.
   always_comb begin
      mis_x        = (x_i !== exp_x);
      mis_yz       = (y_i !== exp_y) | (z_i !== exp_z);
      mismatch     = mis_x | mis_yz;
      start_accept = (state_q == IDLE) && start;
   end

   // Next-state and datapath updates for the sweep sequencer.
   always_comb begin
      state_d     = state_q;
      vec_d       = vec_q;
      cnt_d       = cnt_q;
      done_d      = 1'b0;
      pass_d      = pass_q;
      err_cnt_d   = err_cnt_q;
      fail_mask_d = fail_mask_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               vec_d       = '0;
               err_cnt_d   = '0;
               fail_mask_d = '0;
               pass_d      = 1'b0;
               cnt_d       = SETTLE_LOAD;
               state_d     = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q == 4'd0) begin
               state_d = CHECK;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         CHECK: begin
            if (mismatch) begin
               err_cnt_d          = err_cnt_q + ERR_W'(1);
               fail_mask_d[vec_q] = 1'b1;
            end
            if (vec_q == LAST_VEC) begin
               state_d = DONE;
            end else begin
               vec_d   = vec_q + VEC_W'(1);
               cnt_d   = SETTLE_LOAD;
               state_d = SETTLE;
            end
         end
         DONE: begin
            // err_cnt_q already includes the final CHECK result here.
            done_d  = 1'b1;
            pass_d  = (err_cnt_q == '0);
            vec_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         vec_q       <= '0;
         cnt_q       <= '0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_cnt_q   <= '0;
         fail_mask_q <= '0;
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         cnt_q       <= cnt_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_cnt_q   <= err_cnt_d;
         fail_mask_q <= fail_mask_d;
      end
   end

`ifdef LOGIC_TEST_CHECKER_FAIL_LOG_EN
   logic [4:0] first_fail_q, first_fail_d;

   // Capture only the first failing vector of a sweep; cleared on start.
   always_comb begin
      first_fail_d = first_fail_q;
      if (start_accept) begin
         first_fail_d = '0;
      end else if ((state_q == CHECK) && mismatch && !first_fail_q[4]) begin
         first_fail_d = {1'b1, vec_q, mis_x, mis_yz};
      end
   end

   // First-failure log register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_fail_q <= '0;
      end else begin
         first_fail_q <= first_fail_d;
      end
   end

   assign first_fail = first_fail_q;
`else
   logic unused_log;
   assign unused_log = start_accept ^ mis_x ^ mis_yz;
   assign first_fail = '0;
`endif

   assign a_o       = vec_q[1];
   assign b_o       = vec_q[0];
   assign busy      = (state_q == SETTLE) || (state_q == CHECK);
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_cnt   = err_cnt_q;
   assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_logic_test_checker.sv
// Directed bench for logic_test_checker: a behavioural gate block with
// selectable faults feeds the default instance, and two extra instances with
// SETTLE_CYC=1 and 3 drive a gate block whose outputs lag by two cycles.
module tb_logic_test_checker;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- main instance ----------------
   logic       start = 1'b0;
   logic       a_o, b_o, x_i, y_i, z_i;
   logic       busy, done, pass;
   logic [2:0] err_cnt;
   logic [3:0] fail_mask;
   logic [4:0] first_fail;
   int         fault_mode = 0;  // 0 good, 1 X stuck-at-0, 2 Z is XNOR

   logic_test_checker #(.SETTLE_CYC(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a_o(a_o), .b_o(b_o), .x_i(x_i), .y_i(y_i), .z_i(z_i),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
      .fail_mask(fail_mask), .first_fail(first_fail)
   );

   always_comb begin
      x_i = (fault_mode == 1) ? 1'b0 : (a_o & b_o);
      y_i = a_o | b_o;
      z_i = (fault_mode == 2) ? ~(a_o ^ b_o) : (a_o ^ b_o);
   end

   // ---------------- slow-gate instances ----------------
   logic       start_s = 1'b0;
   logic       a1, b1, busy1, done1, pass1;
   logic       a3, b3, busy3, done3, pass3;
   logic [2:0] err1, err3;
   logic [3:0] mask1, mask3;
   logic [4:0] ff1, ff3;
   logic [2:0] d1_1, d2_1, d1_3, d2_3;

   // Two-stage delayed gate outputs for each slow instance.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d1_1 <= '0; d2_1 <= '0; d1_3 <= '0; d2_3 <= '0;
      end else begin
         d1_1 <= {a1 & b1, a1 | b1, a1 ^ b1};
         d2_1 <= d1_1;
         d1_3 <= {a3 & b3, a3 | b3, a3 ^ b3};
         d2_3 <= d1_3;
      end
   end

   logic_test_checker #(.SETTLE_CYC(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_s),
      .a_o(a1), .b_o(b1), .x_i(d2_1[2]), .y_i(d2_1[1]), .z_i(d2_1[0]),
      .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
      .fail_mask(mask1), .first_fail(ff1)
   );

   logic_test_checker #(.SETTLE_CYC(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start_s),
      .a_o(a3), .b_o(b3), .x_i(d2_3[2]), .y_i(d2_3[1]), .z_i(d2_3[0]),
      .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
      .fail_mask(mask3), .first_fail(ff3)
   );

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] ff_exp(input logic [4:0] logged);
`ifdef LOGIC_TEST_CHECKER_FAIL_LOG_EN
      return logged;
`else
      return (logged & 5'd0);
`endif
   endfunction

   // ---------------- driver tasks ----------------
   // Pulse start for one cycle on the main instance and follow the sweep.
   task automatic run_sweep(output int done_cyc, output int busy_cnt, output logic [7:0] vecs);
      int cyc;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0; busy_cnt = 0; vecs = '0;
      while (!done && cyc < 60) begin
         if (busy) busy_cnt++;
         if (cyc == 1 || cyc == 4 || cyc == 7 || cyc == 10) vecs = {vecs[5:0], a_o, b_o};
         @(posedge clk); #1;
         cyc++;
      end
      done_cyc = done ? cyc : -1;
   endtask

   // ---------------- stimulus ----------------
   int         dc, bc, d1c, d3c;
   logic [7:0] vseq;
   logic       seen_done, stable_bad;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_outputs",
               {16'd0, a_o, b_o, busy, done, pass, err_cnt, fail_mask, first_fail}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Good gate block
      fault_mode = 0;
      run_sweep(dc, bc, vseq);
      check_eq("good_done_cycle", dc, 13);
      check_eq("good_busy_cycles", bc, 12);
      check_eq("good_vec_order", {24'd0, vseq}, 32'h1B);
      check_eq("good_pass", pass, 1);
      check_eq("good_err_cnt", err_cnt, 0);
      check_eq("good_fail_mask", fail_mask, 0);
      check_eq("good_first_fail", first_fail, ff_exp(5'd0));
      @(posedge clk); #1;
      check_eq("good_done_one_cycle", done, 0);
      check_eq("good_pass_hold", pass, 1);

      // X stuck at 0: only vector 11 fails, X disagrees
      fault_mode = 1;
      run_sweep(dc, bc, vseq);
      check_eq("xstuck_done_cycle", dc, 13);
      check_eq("xstuck_pass", pass, 0);
      check_eq("xstuck_err_cnt", err_cnt, 1);
      check_eq("xstuck_fail_mask", fail_mask, 4'b1000);
      check_eq("xstuck_first_fail", first_fail, ff_exp(5'b1_11_10));

      // Z is XNOR: every vector fails, first failure on 00 through Z
      fault_mode = 2;
      run_sweep(dc, bc, vseq);
      check_eq("xnor_pass", pass, 0);
      check_eq("xnor_err_cnt", err_cnt, 4);
      check_eq("xnor_fail_mask", fail_mask, 4'b1111);
      check_eq("xnor_first_fail", first_fail, ff_exp(5'b1_00_01));
      repeat (3) @(posedge clk); #1;
      check_eq("xnor_status_hold", {err_cnt, fail_mask}, {3'd4, 4'b1111});

      // Reset during vector 01 SETTLE
      fault_mode = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk); #1;
      check_eq("midrst_in_vec01", {busy, a_o, b_o}, 3'b101);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_outputs",
               {16'd0, a_o, b_o, busy, done, pass, err_cnt, fail_mask, first_fail}, 32'd0);
      seen_done = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done) seen_done = 1'b1;
      end
      rst_n = 1'b1;
      repeat (15) begin
         @(posedge clk); #1;
         if (done) seen_done = 1'b1;
      end
      check_eq("midrst_no_done", seen_done, 0);
      run_sweep(dc, bc, vseq);
      check_eq("midrst_resweep_cycle", dc, 13);
      check_eq("midrst_resweep_pass", {pass, err_cnt, fail_mask}, {1'b1, 3'd0, 4'd0});

      // start held high for 40 edges: back-to-back sweeps
      exp_q.push_back(13);
      exp_q.push_back(27);
      exp_q.push_back(41);
      stable_bad = 1'b0;
      start = 1'b1;
      for (int i = 0; i < 46; i++) begin
         @(posedge clk); #1;
         if (i == 39) start = 1'b0;
         if (err_cnt != 0 || fail_mask != 0) stable_bad = 1'b1;
         if (done) begin
            if (exp_q.size() == 0) check_eq("held_extra_done", i, 0);
            else check_eq("held_done_cycle", i, exp_q.pop_front());
         end
      end
      check_eq("held_missing_done", exp_q.size(), 0);
      check_eq("held_status_stable", stable_bad, 0);
      check_eq("held_final_pass", pass, 1);

      // Delayed gate block: SETTLE_CYC=1 too short, SETTLE_CYC=3 enough
      repeat (3) @(posedge clk); #1;
      start_s = 1'b1;
      @(posedge clk); #1;
      start_s = 1'b0;
      d1c = -1; d3c = -1;
      for (int i = 1; i < 40 && d3c < 0; i++) begin
         @(posedge clk); #1;
         if (done1 && d1c < 0) d1c = i;
         if (done3) d3c = i;
      end
      check_eq("slow1_done_cycle", d1c, 9);
      check_eq("slow3_done_cycle", d3c, 17);
      check_eq("slow1_result", {pass1, err1, mask1}, {1'b0, 3'd2, 4'b1010});
      check_eq("slow1_first_fail", ff1, ff_exp(5'b1_01_01));
      check_eq("slow3_result", {pass3, err3, mask3}, {1'b1, 3'd0, 4'b0000});

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
